// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins contention unless fetch has waited STARVE_LIMIT data grants in a row.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_kill,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_if,
  output logic                    stall_mem
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, next_state;
  owner_t     owner;
  logic       drop;
  logic [3:0] starve_cnt;
  logic       start;
  logic       pick_d;
  logic       rsp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = if_req | d_req;
    pick_d     = d_req & (~if_req | (starve_cnt < LIMIT));
    case (state)
      IDLE:     if (start)      next_state = WAIT_GNT;
      WAIT_GNT: if (mem_gnt)    next_state = WAIT_RSP;
      WAIT_RSP: if (mem_rvalid) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Response data is shared; only the completion pulses are steered to the owner.
  always_comb begin
    mem_req   = (state == WAIT_GNT);
    rsp       = (state == WAIT_RSP) & mem_rvalid;
    d_valid   = rsp & (owner == OWN_D);
    if_valid  = rsp & (owner == OWN_IF) & ~drop & ~if_kill;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    stall_if  = if_req & ~if_valid;
    stall_mem = d_req & ~d_valid;
  end

  // A killed fetch still runs to completion on the memory side; only its pulse is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_IF;
      drop       <= 1'b0;
      starve_cnt <= 4'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else if (state == IDLE && start) begin
      drop <= 1'b0;
      if (pick_d) begin
        owner     <= OWN_D;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        if (if_req && starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        owner      <= OWN_IF;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        mem_be     <= '1;
        starve_cnt <= 4'd0;
      end
    end else if (state != IDLE && owner == OWN_IF && if_kill) begin
      drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus hand-written
// sequences for back-pressure, contention and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_kill, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_if, stall_mem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // stim bits: {if_req, if_kill, d_req, mem_gnt, mem_rvalid}
  // expect bits: {mem_req, if_valid, d_valid, stall_if, stall_mem}
  typedef struct {
    logic [4:0]  stim;
    logic [31:0] if_a;
    logic [31:0] d_a;
    logic [31:0] rdata;
    logic [4:0]  expect_bits;
    logic [31:0] expect_addr;
  } vec_t;

  vec_t vecs[22];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    if_req     = v.stim[4];
    if_kill    = v.stim[3];
    d_req      = v.stim[2];
    mem_gnt    = v.stim[1];
    mem_rvalid = v.stim[0];
    if_addr    = v.if_a;
    d_addr     = v.d_a;
    mem_rdata  = v.rdata;
    d_we       = 1'b0;
  endtask

  // Acts as the memory for one transaction: wait for mem_req, grant, then respond.
  task automatic serve_one(input bit exp_d, input logic [31:0] exp_addr, input logic [31:0] rd);
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    check_output("serve_req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check_output("serve_addr", mem_addr, exp_addr);
    check_output("serve_we", 32'(mem_we), exp_d ? 32'd1 : 32'd0);
    check_output("serve_be", 32'(mem_be), exp_d ? 32'h5 : 32'hF);
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clk);
    check_output("serve_d_valid", 32'(d_valid), exp_d ? 32'd1 : 32'd0);
    check_output("serve_if_valid", 32'(if_valid), exp_d ? 32'd0 : 32'd1);
    check_output("serve_rdata", exp_d ? d_rdata : if_rdata, rd);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          seen;
    logic [31:0] stable_addr;

    vecs[0]  = '{5'b00100, 32'h0,   32'h100, 32'h0,        5'b00001, 32'h0};
    vecs[1]  = '{5'b00110, 32'h0,   32'h100, 32'h0,        5'b10001, 32'h100};
    vecs[2]  = '{5'b00101, 32'h0,   32'h100, 32'hDEADBEEF, 5'b00100, 32'h100};
    vecs[3]  = '{5'b00000, 32'h0,   32'h0,   32'h0,        5'b00000, 32'h100};
    vecs[4]  = '{5'b00001, 32'h0,   32'h0,   32'h55,       5'b00000, 32'h100};
    vecs[5]  = '{5'b00000, 32'h0,   32'h0,   32'h0,        5'b00000, 32'h100};
    vecs[6]  = '{5'b10000, 32'h200, 32'h0,   32'h0,        5'b00010, 32'h100};
    vecs[7]  = '{5'b10010, 32'h200, 32'h0,   32'h0,        5'b10010, 32'h200};
    vecs[8]  = '{5'b11000, 32'h300, 32'h0,   32'h0,        5'b00010, 32'h200};
    vecs[9]  = '{5'b10001, 32'h300, 32'h0,   32'hAAAA,     5'b00010, 32'h200};
    vecs[10] = '{5'b10000, 32'h300, 32'h0,   32'h0,        5'b00010, 32'h200};
    vecs[11] = '{5'b10010, 32'h300, 32'h0,   32'h0,        5'b10010, 32'h300};
    vecs[12] = '{5'b10001, 32'h300, 32'h0,   32'h13,       5'b01000, 32'h300};
    vecs[13] = '{5'b00000, 32'h0,   32'h0,   32'h0,        5'b00000, 32'h300};
    vecs[14] = '{5'b10000, 32'h400, 32'h0,   32'h0,        5'b00010, 32'h300};
    vecs[15] = '{5'b10010, 32'h400, 32'h0,   32'h0,        5'b10010, 32'h400};
    vecs[16] = '{5'b11001, 32'h400, 32'h0,   32'h77,       5'b00010, 32'h400};
    vecs[17] = '{5'b00000, 32'h0,   32'h0,   32'h0,        5'b00000, 32'h400};
    vecs[18] = '{5'b00100, 32'h0,   32'h500, 32'h0,        5'b00001, 32'h400};
    vecs[19] = '{5'b01110, 32'h0,   32'h500, 32'h0,        5'b10001, 32'h500};
    vecs[20] = '{5'b01101, 32'h0,   32'h500, 32'h99,       5'b00100, 32'h500};
    vecs[21] = '{5'b00000, 32'h0,   32'h0,   32'h0,        5'b00000, 32'h500};

    rst_n = 1'b0;
    if_req = 1'b1; if_kill = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_mem_be", 32'(mem_be), 32'h0);
    check_output("rst_if_valid", 32'(if_valid), 32'd0);
    check_output("rst_d_valid", 32'(d_valid), 32'd0);
    check_output("rst_stall_if", 32'(stall_if), 32'd1);
    check_output("rst_stall_mem", 32'(stall_mem), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].expect_bits[4]));
      check_output($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].expect_bits[3]));
      check_output($sformatf("v%0d_d_valid", i), 32'(d_valid), 32'(vecs[i].expect_bits[2]));
      check_output($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].expect_bits[1]));
      check_output($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].expect_bits[0]));
      check_output($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].expect_addr);
      if (vecs[i].expect_bits[3]) check_output($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].rdata);
      if (vecs[i].expect_bits[2]) check_output($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].rdata);
    end

    // Store held off by five cycles of missing grant.
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    check_output("bp_req_seen", 32'(seen), 32'd1);
    stable_addr = 32'h40;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("bp%0d_mem_req", k), 32'(mem_req), 32'd1);
      check_output($sformatf("bp%0d_mem_we", k), 32'(mem_we), 32'd1);
      check_output($sformatf("bp%0d_mem_addr", k), mem_addr, stable_addr);
      check_output($sformatf("bp%0d_mem_wdata", k), mem_wdata, 32'h12345678);
      check_output($sformatf("bp%0d_mem_be", k), 32'(mem_be), 32'h3);
      check_output($sformatf("bp%0d_d_valid", k), 32'(d_valid), 32'd0);
      check_output($sformatf("bp%0d_stall_mem", k), 32'(stall_mem), 32'd1);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    check_output("bp_d_valid", 32'(d_valid), 32'd1);
    check_output("bp_stall_mem", 32'(stall_mem), 32'd0);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_output("bp_d_valid_once", 32'(d_valid), 32'd0);

    // Both requesters held: four data grants, then one fetch, repeating.
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_be = 4'b0101;
    for (int g = 0; g < 10; g++) begin
      if ((g % 5) == 4) serve_one(1'b0, 32'h1000, 32'hF000 + 32'(g));
      else              serve_one(1'b1, 32'h2000, 32'hD000 + 32'(g));
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while a data access waits for grant; starvation count must restart.
    #1;
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h100;
    serve_one(1'b1, 32'h100, 32'h1);
    serve_one(1'b1, 32'h100, 32'h2);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1;
        break;
      end
    end
    check_output("rwg_req_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rwg_mem_req", 32'(mem_req), 32'd0);
    check_output("rwg_mem_addr", mem_addr, 32'h0);
    check_output("rwg_if_valid", 32'(if_valid), 32'd0);
    check_output("rwg_d_valid", 32'(d_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    serve_one(1'b1, 32'h100, 32'hDEADBEEF);
    serve_one(1'b1, 32'h100, 32'h3);
    serve_one(1'b1, 32'h100, 32'h4);
    serve_one(1'b1, 32'h100, 32'h5);
    serve_one(1'b0, 32'h1000, 32'h6);
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
